// File: rtl/uart_frame_responder.sv
// uart_frame_responder: device end of the host link. It parses HDR, LEN, payload and CHK
// frames from the UART receiver and answers with an ACK or NAK frame through the transmitter.
// Optional macro PAYLOAD_ECHO_EN: the ACK also echoes LEN and the payload, which adds a
// MAX_LEN x 8 payload buffer.
module uart_frame_responder #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HDR         = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] r_data,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       frame_ok_tick,
  output logic       frame_err_tick,
  output logic [7:0] err_code
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen  = 3'd1;
  localparam logic [2:0] StPay  = 3'd2;
  localparam logic [2:0] StChk  = 3'd3;
  localparam logic [2:0] StDec  = 3'd4;  // decision pulse cycle, first byte loaded
  localparam logic [2:0] StSend = 3'd5;
  localparam logic [2:0] StWait = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_q, ack_d;
  logic [7:0]    err_code_q, err_code_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    w_data_q, w_data_d;
  logic [8:0]    tx_idx_q, tx_idx_d;  // 9 bits: an echoed ACK can be LEN+3 bytes long

  logic       in_get;
  logic       timeout;
  logic       err_set;
  logic [7:0] err_val;
  logic [8:0] nxt_idx;
  logic [8:0] last_idx;
  logic [7:0] next_byte;

  assign in_get  = (state_q == StLen) || (state_q == StPay) || (state_q == StChk);
  // A byte in the expiry cycle takes priority over the timeout.
  assign timeout = (timer_q == TW'(TIMEOUT_CYC - 1)) && !rx_done_tick;
  assign nxt_idx = tx_idx_q + 9'd1;

`ifdef PAYLOAD_ECHO_EN
  logic [7:0] buf_q [MAX_LEN];
  logic [7:0] echo_byte;
  logic [7:0] echo_sel;

  // Payload capture; data registers need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((state_q == StPay) && rx_done_tick && (idx_q == 8'(i))) buf_q[i] <= r_data;
    end
  end

  // Select the payload byte for echo slot nxt_idx (payload starts at response index 2).
  always_comb begin
    echo_sel  = 8'(nxt_idx - 9'd2);
    echo_byte = 8'h00;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (echo_sel == 8'(i)) echo_byte = buf_q[i];
    end
  end

  assign last_idx = ack_q ? ({1'b0, len_q} + 9'd2) : 9'd1;

  // Byte following the current one in the response.
  always_comb begin
    next_byte = err_code_q;
    if (ack_q) begin
      if (nxt_idx == 9'd1)          next_byte = len_q;
      else if (nxt_idx == last_idx) next_byte = acc_q;
      else                          next_byte = echo_byte;
    end
  end
`else
  assign last_idx  = 9'd1;
  // Byte following the current one in the response.
  assign next_byte = ack_q ? acc_q : err_code_q;
`endif

  // Parser, timeout and response sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    timer_d     = '0;
    ack_d       = ack_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    w_data_d    = w_data_q;
    tx_idx_d    = tx_idx_q;
    err_set     = 1'b0;
    err_val     = 8'h00;

    if (in_get && !rx_done_tick) timer_d = timer_q + TW'(1);

    case (state_q)
      StIdle: begin
        if (rx_done_tick && (r_data == HDR)) begin
          state_d = StLen;
          acc_d   = 8'h00;
          idx_d   = 8'h00;
        end
      end
      StLen: begin
        if (rx_done_tick) begin
          if ((r_data == 8'h00) || (r_data > 8'(MAX_LEN))) begin
            err_set = 1'b1;
            err_val = 8'h02;
          end else begin
            len_d   = r_data;
            acc_d   = r_data;
            idx_d   = 8'h00;
            state_d = StPay;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          err_val = 8'h03;
        end
      end
      StPay: begin
        if (rx_done_tick) begin
          acc_d = acc_q + r_data;
          idx_d = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q) state_d = StChk;
        end else if (timeout) begin
          err_set = 1'b1;
          err_val = 8'h03;
        end
      end
      StChk: begin
        if (rx_done_tick) begin
          if (r_data == acc_q) begin
            frame_ok_d = 1'b1;
            ack_d      = 1'b1;
            state_d    = StDec;
          end else begin
            err_set = 1'b1;
            err_val = 8'h01;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          err_val = 8'h03;
        end
      end
      StDec: begin
        tx_idx_d = 9'd0;
        w_data_d = ack_q ? 8'h06 : 8'h15;
        state_d  = StSend;
      end
      StSend: state_d = StWait;
      StWait: begin
        if (tx_done_tick) begin
          if (tx_idx_q == last_idx) begin
            state_d = StIdle;
          end else begin
            tx_idx_d = nxt_idx;
            w_data_d = next_byte;
            state_d  = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_set) begin
      frame_err_d = 1'b1;
      err_code_d  = err_val;
      ack_d       = 1'b0;
      state_d     = StDec;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= 8'h00;
      acc_q       <= 8'h00;
      idx_q       <= 8'h00;
      timer_q     <= '0;
      ack_q       <= 1'b0;
      err_code_q  <= 8'h00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      w_data_q    <= 8'h00;
      tx_idx_q    <= 9'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      err_code_q  <= err_code_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      w_data_q    <= w_data_d;
      tx_idx_q    <= tx_idx_d;
    end
  end

  assign tx_start       = (state_q == StSend);
  assign w_data         = w_data_q;
  assign busy           = (state_q != StIdle) && (state_q != StLen);
  assign frame_ok_tick  = frame_ok_q;
  assign frame_err_tick = frame_err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_uart_frame_responder.sv
// Scoreboard bench for uart_frame_responder: stimulus pushes expected TX bytes and decision
// events; monitors pop and compare when the DUT emits tx_start or a frame tick.
module tb_uart_frame_responder;

  localparam int unsigned MAX_LEN     = 16;
  localparam int unsigned TIMEOUT_CYC = 40;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    bit         ok;
    logic [7:0] code;
    int         at;  // expected tick cycle, -1 when unchecked
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start, busy, frame_ok_tick, frame_err_tick;
  logic [7:0] w_data, err_code;

  uart_frame_responder #(
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .HDR        (8'hA5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_done_tick  (rx_done_tick),
    .r_data        (r_data),
    .tx_done_tick  (tx_done_tick),
    .tx_start      (tx_start),
    .w_data        (w_data),
    .busy          (busy),
    .frame_ok_tick (frame_ok_tick),
    .frame_err_tick(frame_err_tick),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  ev_t        ev_q[$];
  int         vec = 0;
  int         mis = 0;
  int         last_rx_cyc = 0;
  int         dec_cyc = 0;
  bit         first_pending = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] held_code = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decision monitor.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (frame_ok_tick || frame_err_tick)) begin
      dec_cyc       = cyc;
      first_pending = 1'b1;
      if (ev_q.size() == 0) begin
        chk("unexpected_tick", 32'd1, 32'd0);
      end else begin
        e = ev_q.pop_front();
        chk("tick_ok", 32'(frame_ok_tick), 32'(e.ok));
        chk("tick_err", 32'(frame_err_tick), 32'(!e.ok));
        chk("err_code", 32'(err_code), 32'(e.code));
        if (e.at >= 0) chk("tick_cycle", cyc, e.at);
      end
    end
  end

  // Transmitter model and TX byte monitor.
  always begin
    logic [7:0] hold;
    bit         ok;
    bit         abort;
    @(negedge clk);
    if (tx_start && !reset) begin
      tx_cnt++;
      if (exp_q.size() == 0) chk("unexpected_tx", 32'(w_data), 32'hFFFF);
      else chk("tx_byte", 32'(w_data), 32'(exp_q.pop_front()));
      if (first_pending) begin
        chk("tx_latency", cyc, dec_cyc + 1);
        first_pending = 1'b0;
      end
      hold  = w_data;
      ok    = 1'b1;
      abort = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (reset) abort = 1'b1;
        if (!abort && ((w_data !== hold) || (tx_start !== 1'b0))) ok = 1'b0;
      end
      if (!abort) chk("tx_hold", 32'(ok), 32'd1);
      @(posedge clk); #1 tx_done_tick = 1'b1;
      @(posedge clk); #1 tx_done_tick = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    r_data       = b;
    last_rx_cyc  = cyc;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 3000);
    if (n >= 3000) chk("idle_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_low", 32'(busy), 32'd0);
    chk("events_drained", ev_q.size(), 32'd0);
  endtask

  task automatic push_ack(input byte_q_t f);
    ev_q.push_back('{ok: 1'b1, code: held_code, at: -1});
    exp_q.push_back(8'h06);
`ifdef PAYLOAD_ECHO_EN
    for (int i = 1; i < f.size() - 1; i++) exp_q.push_back(f[i]);
`endif
    exp_q.push_back(f[f.size()-1]);
  endtask

  task automatic push_nak(input logic [7:0] code, input int at);
    ev_q.push_back('{ok: 1'b0, code: code, at: at});
    exp_q.push_back(8'h15);
    exp_q.push_back(code);
    held_code = code;
  endtask

  task automatic send_all(input byte_q_t f);
    for (int i = 0; i < f.size(); i++) send_byte(f[i]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_w_data"}, 32'(w_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ok_tick"}, 32'(frame_ok_tick), 32'd0);
    chk({tag, "_err_tick"}, 32'(frame_err_tick), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    held_code = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    byte_q_t f;
    int      base;
    int      n;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outs("por");

    // Good frame.
    f = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    push_ack(f);
    send_all(f);
    wait_idle();

    // Bad checksum.
    push_nak(8'h01, -1);
    f = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_all(f);
    wait_idle();

    // Zero length, then length one above MAX_LEN.
    push_nak(8'h02, -1);
    f = {8'hA5, 8'h00};
    send_all(f);
    wait_idle();
    push_nak(8'h02, -1);
    f = {8'hA5, 8'h11};
    send_all(f);
    wait_idle();

    // Stall after a payload byte; a byte one cycle too late is dropped.
    f = {8'hA5, 8'h02, 8'h10};
    send_all(f);
    push_nak(8'h03, last_rx_cyc + TIMEOUT_CYC + 1);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    send_byte(8'h20);
    wait_idle();

    // Next byte lands exactly on the expiry cycle: frame continues and is ACKed.
    f = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    push_ack(f);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    repeat (TIMEOUT_CYC - 2) @(posedge clk);
    send_byte(8'h20);
    send_byte(8'h32);
    wait_idle();

    // Garbage before a frame whose checksum wraps.
    f = {8'h00, 8'hFF, 8'h3C};
    send_all(f);
    f = {8'hA5, 8'h01, 8'hFF, 8'h00};
    push_ack(f);
    send_all(f);
    wait_idle();

    // Reset in the middle of the payload.
    f = {8'hA5, 8'h03, 8'h01};
    send_all(f);
    pulse_reset();
    chk_reset_outs("rst_pay");
    f = {8'hA5, 8'h02, 8'h05, 8'h06, 8'h0D};
    push_ack(f);
    send_all(f);
    wait_idle();

    // Reset while waiting on the second response byte.
    f = {8'hA5, 8'h01, 8'h40, 8'h41};
    push_ack(f);
    base = tx_cnt;
    send_all(f);
    n = 0;
    while ((tx_cnt < base + 2) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("second_byte_timeout", 32'd0, 32'd1);
    pulse_reset();
    chk_reset_outs("rst_wait");
    exp_q.delete();
    repeat (10) @(posedge clk);
    f = {8'hA5, 8'h02, 8'h7F, 8'h01, 8'h82};
    push_ack(f);
    send_all(f);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
